// File: rtl/ctrl_hazard_stage_if.sv
// ID/EX control stage bus: decoded ID fields in, registered EX fields and
// hazard status out. The master modport is the pipeline around the stage,
// and the slave modport is the stage itself.
interface ctrl_hazard_stage_if #(
  parameter int CTRL_W = 16,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              flush;
  logic              ext_stall;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              stall_req;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_ctrl, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_is_load, flush, ext_stall,
    input  ex_ctrl, ex_valid, ex_rd, ex_is_load, stall_req, bubble_cnt
  );

  modport slave (
    input  id_ctrl, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_is_load, flush, ext_stall,
    output ex_ctrl, ex_valid, ex_rd, ex_is_load, stall_req, bubble_cnt
  );
endinterface

// File: rtl/ctrl_hazard_stage.sv
// ID/EX control pipeline register with load-use bubble insertion.
//
// state | meaning
// RUN   | normal flow; a load-use hazard inserts the first bubble
// STALL | inserting the remaining bubbles, scnt of them still to go
//
// Priority at each edge: rst > flush > ext_stall > bubble > normal load.
module ctrl_hazard_stage #(
  parameter int                CTRL_W     = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = '0,
  parameter int                REG_AW     = 5,
  parameter int                LU_STALL   = 1,
  parameter int                CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  ctrl_hazard_stage_if.slave bus
);
  localparam int SCNT_W = $clog2(LU_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state, state_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_nxt;
  logic              ex_valid_q, ex_valid_nxt;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_nxt;
  logic              ex_is_load_q, ex_is_load_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              bubble;
  logic              hz;

  // Load-use hazard: ID reads the register that the load in EX will write; x0 is exempt.
  always_comb begin
    hz = bus.id_valid & ex_valid_q & ex_is_load_q & (ex_rd_q != '0) &
         ((bus.id_rs1_used & (bus.id_rs1 == ex_rd_q)) |
          (bus.id_rs2_used & (bus.id_rs2 == ex_rd_q)));
  end

  // Next-state logic: FSM, stall counter and EX register contents.
  always_comb begin
    state_nxt      = state;
    scnt_nxt       = scnt;
    ex_ctrl_nxt    = ex_ctrl_q;
    ex_valid_nxt   = ex_valid_q;
    ex_rd_nxt      = ex_rd_q;
    ex_is_load_nxt = ex_is_load_q;
    bubble         = 1'b0;
    if (bus.flush) begin
      bubble    = 1'b1;
      state_nxt = RUN;
      scnt_nxt  = '0;
    end else if (bus.ext_stall) begin
      bubble = 1'b0;
    end else if (state == STALL) begin
      bubble   = 1'b1;
      scnt_nxt = scnt - SCNT_W'(1);
      if (scnt == SCNT_W'(1)) state_nxt = RUN;
    end else if (hz) begin
      bubble = 1'b1;
      if (LU_STALL > 1) begin
        state_nxt = STALL;
        scnt_nxt  = SCNT_W'(LU_STALL - 1);
      end
    end else begin
      ex_ctrl_nxt    = bus.id_valid ? bus.id_ctrl : BUBBLE_VAL;
      ex_valid_nxt   = bus.id_valid;
      ex_rd_nxt      = bus.id_rd;
      ex_is_load_nxt = bus.id_is_load;
    end
    if (bubble) begin
      ex_ctrl_nxt    = BUBBLE_VAL;
      ex_valid_nxt   = 1'b0;
      ex_rd_nxt      = '0;
      ex_is_load_nxt = 1'b0;
    end
    cnt_nxt = (bubble && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and EX register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      scnt         <= '0;
      ex_ctrl_q    <= BUBBLE_VAL;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= '0;
      ex_is_load_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state        <= state_nxt;
      scnt         <= scnt_nxt;
      ex_ctrl_q    <= ex_ctrl_nxt;
      ex_valid_q   <= ex_valid_nxt;
      ex_rd_q      <= ex_rd_nxt;
      ex_is_load_q <= ex_is_load_nxt;
      cnt_q        <= cnt_nxt;
    end
  end

  // Freeze upstream whenever this stage will not accept the ID instruction; flush releases it.
  always_comb begin
    bus.stall_req = !bus.flush & (bus.ext_stall | ((state == RUN) & hz) | (state == STALL));
  end

  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// Bench for ctrl_hazard_stage: two instances share one stimulus stream,
// A with LU_STALL=2 / CNT_W=16 and B with LU_STALL=3 / CNT_W=4.
module tb_ctrl_hazard_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] id_ctrl = '0;
  logic id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic rs1_used = 1'b0, rs2_used = 1'b0, id_is_load = 1'b0;
  logic flush = 1'b0, ext_stall = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_hazard_stage_if #(.CNT_W(16)) ifa ();
  ctrl_hazard_stage_if #(.CNT_W(4))  ifb ();

  assign ifa.id_ctrl = id_ctrl;      assign ifb.id_ctrl = id_ctrl;
  assign ifa.id_valid = id_valid;    assign ifb.id_valid = id_valid;
  assign ifa.id_rs1 = id_rs1;        assign ifb.id_rs1 = id_rs1;
  assign ifa.id_rs2 = id_rs2;        assign ifb.id_rs2 = id_rs2;
  assign ifa.id_rs1_used = rs1_used; assign ifb.id_rs1_used = rs1_used;
  assign ifa.id_rs2_used = rs2_used; assign ifb.id_rs2_used = rs2_used;
  assign ifa.id_rd = id_rd;          assign ifb.id_rd = id_rd;
  assign ifa.id_is_load = id_is_load; assign ifb.id_is_load = id_is_load;
  assign ifa.flush = flush;          assign ifb.flush = flush;
  assign ifa.ext_stall = ext_stall;  assign ifb.ext_stall = ext_stall;

  ctrl_hazard_stage #(.LU_STALL(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ctrl_hazard_stage #(.LU_STALL(3), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Observed outputs gathered per instance for loop-based comparison.
  logic [15:0] d_ctrl[2];
  logic        d_valid[2];
  logic [4:0]  d_rd[2];
  logic        d_ld[2];
  logic        d_sreq[2];
  logic [15:0] d_cnt[2];
  assign d_ctrl[0] = ifa.ex_ctrl;    assign d_ctrl[1] = ifb.ex_ctrl;
  assign d_valid[0] = ifa.ex_valid;  assign d_valid[1] = ifb.ex_valid;
  assign d_rd[0] = ifa.ex_rd;        assign d_rd[1] = ifb.ex_rd;
  assign d_ld[0] = ifa.ex_is_load;   assign d_ld[1] = ifb.ex_is_load;
  assign d_sreq[0] = ifa.stall_req;  assign d_sreq[1] = ifb.stall_req;
  assign d_cnt[0] = ifa.bubble_cnt;  assign d_cnt[1] = {12'b0, ifb.bubble_cnt};

  // Reference model: EX contents plus a count of bubbles still owed.
  typedef struct {
    logic [15:0] ctrl;
    logic        v;
    logic [4:0]  rd;
    logic        ld;
    int          cnt;
    int          owed;
  } mdl_t;
  mdl_t m[2];
  int lu[2]   = '{2, 3};
  int cmax[2] = '{65535, 15};

  function automatic logic m_hz(int k);
    return id_valid && m[k].v && m[k].ld && (m[k].rd != 0) &&
           ((rs1_used && id_rs1 == m[k].rd) || (rs2_used && id_rs2 == m[k].rd));
  endfunction

  function automatic logic m_sreq(int k);
    return !flush && (ext_stall || m[k].owed > 0 || m_hz(k));
  endfunction

  function automatic mdl_t m_bubble(mdl_t s, int k);
    mdl_t r = s;
    r.ctrl = 16'h0; r.v = 1'b0; r.rd = 5'd0; r.ld = 1'b0;
    if (r.cnt < cmax[k]) r.cnt = r.cnt + 1;
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) m[k] = '{16'h0, 1'b0, 5'd0, 1'b0, 0, 0};
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      logic h;
      h = m_hz(k);
      if (rst) begin
        m[k] = '{16'h0, 1'b0, 5'd0, 1'b0, 0, 0};
      end else if (flush) begin
        m[k] = m_bubble(m[k], k);
        m[k].owed = 0;
      end else if (ext_stall) begin
        m[k] = m[k];
      end else if (m[k].owed > 0) begin
        m[k] = m_bubble(m[k], k);
        m[k].owed = m[k].owed - 1;
      end else if (h) begin
        m[k] = m_bubble(m[k], k);
        m[k].owed = lu[k] - 1;
      end else begin
        m[k].ctrl = id_valid ? id_ctrl : 16'h0;
        m[k].v = id_valid; m[k].rd = id_rd; m[k].ld = id_is_load;
      end
    end
    #1;
  endtask

  task automatic set_id(logic [15:0] c, logic v, logic [4:0] r1, logic u1,
                        logic [4:0] r2, logic u2, logic [4:0] rd, logic ld);
    id_ctrl = c; id_valid = v; id_rs1 = r1; rs1_used = u1;
    id_rs2 = r2; rs2_used = u2; id_rd = rd; id_is_load = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    set_id(16'hBEEF, 1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_ctrl[k] !== 16'h0 || d_valid[k] !== 1'b0 || d_cnt[k] !== 16'h0 || d_sreq[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: ctrl=%h valid=%b cnt=%0d sreq=%b, want 0/0/0/0",
                 k, d_ctrl[k], d_valid[k], d_cnt[k], d_sreq[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    set_id(16'h1234, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b0);
    #1;
    checks++;
    if (ifa.stall_req !== 1'b0) begin
      errors++; $display("FAIL pass_sreq: got %b want 0", ifa.stall_req);
    end
    tick();
    checks++;
    if (ifa.ex_ctrl !== 16'h1234 || ifa.ex_valid !== 1'b1 || ifa.ex_rd !== 5'd7) begin
      errors++;
      $display("FAIL pass_ex: ctrl=%h valid=%b rd=%0d want 1234/1/7", ifa.ex_ctrl, ifa.ex_valid, ifa.ex_rd);
    end
  endtask

  task automatic test_load_use();
    set_id(16'h0F00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    set_id(16'h4321, 1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ifa.stall_req !== 1'b1) begin
        errors++; $display("FAIL lu_sreq%0d: got %b want 1", i, ifa.stall_req);
      end
      tick();
      checks++;
      if (ifa.ex_valid !== 1'b0 || ifa.bubble_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL lu_bubble%0d: valid=%b cnt=%0d want 0/%0d", i, ifa.ex_valid, ifa.bubble_cnt, i + 1);
      end
    end
    #1;
    checks++;
    if (ifa.stall_req !== 1'b0) begin
      errors++; $display("FAIL lu_release: sreq=%b want 0", ifa.stall_req);
    end
    tick();
    checks++;
    if (ifa.ex_ctrl !== 16'h4321 || ifa.ex_valid !== 1'b1 || ifa.bubble_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lu_held: ctrl=%h valid=%b cnt=%0d want 4321/1/2", ifa.ex_ctrl, ifa.ex_valid, ifa.bubble_cnt);
    end
  endtask

  task automatic test_x0();
    set_id(16'h0F01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    set_id(16'h0333, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0);
    #1;
    checks++;
    if (ifa.stall_req !== 1'b0) begin
      errors++; $display("FAIL x0_sreq: got %b want 0", ifa.stall_req);
    end
    tick();
    checks++;
    if (ifa.ex_valid !== 1'b1 || ifa.ex_rd !== 5'd3) begin
      errors++; $display("FAIL x0_ex: valid=%b rd=%0d want 1/3", ifa.ex_valid, ifa.ex_rd);
    end
  endtask

  task automatic test_flush_stall();
    rst = 1'b1; tick(); rst = 1'b0;
    set_id(16'h0F02, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    tick();
    set_id(16'h0777, 1'b1, 5'd1, 1'b0, 5'd6, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ifb.stall_req !== 1'b1) begin
        errors++; $display("FAIL fl_sreq%0d: got %b want 1", i, ifb.stall_req);
      end
      tick();
    end
    flush = 1'b1;
    #1;
    checks++;
    if (ifb.stall_req !== 1'b0) begin
      errors++; $display("FAIL fl_drop: sreq=%b want 0", ifb.stall_req);
    end
    tick();
    flush = 1'b0;
    set_id(16'h0ABC, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd4, 1'b0);
    #1;
    checks++;
    if (ifb.stall_req !== 1'b0 || ifb.bubble_cnt !== 4'd3) begin
      errors++; $display("FAIL fl_run: sreq=%b cnt=%0d want 0/3", ifb.stall_req, ifb.bubble_cnt);
    end
    tick();
    checks++;
    if (ifb.ex_ctrl !== 16'h0ABC || ifb.ex_valid !== 1'b1 || ifb.bubble_cnt !== 4'd3) begin
      errors++;
      $display("FAIL fl_next: ctrl=%h valid=%b cnt=%0d want 0abc/1/3", ifb.ex_ctrl, ifb.ex_valid, ifb.bubble_cnt);
    end
  endtask

  task automatic test_ext_stall();
    logic [15:0] c0;
    set_id(16'h00A5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0);
    tick();
    c0 = ifa.bubble_cnt;
    ext_stall = 1'b1;
    set_id(16'h1111, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ifa.stall_req !== 1'b1) begin
        errors++; $display("FAIL es_sreq%0d: got %b want 1", i, ifa.stall_req);
      end
      tick();
      checks++;
      if (ifa.ex_ctrl !== 16'h00A5 || ifa.bubble_cnt !== c0) begin
        errors++;
        $display("FAIL es_hold%0d: ctrl=%h cnt=%0d want 00a5/%0d", i, ifa.ex_ctrl, ifa.bubble_cnt, c0);
      end
    end
    ext_stall = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] c0;
    c0 = ifa.bubble_cnt;
    flush = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b0;
    checks++;
    if (ifb.bubble_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_b: cnt=%h want f", ifb.bubble_cnt);
    end
    checks++;
    if (ifa.bubble_cnt !== c0 + 16'd20) begin
      errors++; $display("FAIL sat_a: cnt=%0d want %0d", ifa.bubble_cnt, c0 + 16'd20);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 7) == 0);
      set_id(16'($urandom), ($urandom_range(0, 4) != 0),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_sreq[k] !== m_sreq(k)) begin
          errors++; $display("FAIL rnd_sreq[%0d] n=%0d: got %b want %b", k, n, d_sreq[k], m_sreq(k));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_ctrl[k] !== m[k].ctrl || d_valid[k] !== m[k].v || d_rd[k] !== m[k].rd ||
            d_ld[k] !== m[k].ld || d_cnt[k] !== 16'(m[k].cnt)) begin
          errors++;
          $display("FAIL rnd_ex[%0d] n=%0d: got %h/%b/%0d/%b/%0d want %h/%b/%0d/%b/%0d", k, n,
                   d_ctrl[k], d_valid[k], d_rd[k], d_ld[k], d_cnt[k],
                   m[k].ctrl, m[k].v, m[k].rd, m[k].ld, m[k].cnt);
        end
      end
    end
    rst = 1'b0; flush = 1'b0; ext_stall = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0();
    test_flush_stall();
    test_ext_stall();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_hazard_stage.md
Name: ctrl_hazard_stage

Overview:
Parametrised ID/EX control pipeline register for the RV32 pipeline. It generalises bubble insertion from a zero-forcing mux into a registered stage. It detects load-use hazards against the instruction in EX and inserts a configurable number of bubble cycles. It also handles branch flush, holds on an external stall, drives the upstream freeze request and counts inserted bubbles.

Parameters:
CTRL_W, 16, width of packed control bundle (Wbsel, MemRw, ALUsel, Asel, Bsel, Rsel, Wsel, RegWrite, spare)
BUBBLE_VAL, {CTRL_W{1'b0}}, control value driven on a bubble/NOP
REG_AW, 5, register-index width
LU_STALL, 1, bubble cycles per load-use hazard (1..3)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_ctrl  in  CTRL_W  decoded control from ID
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  ID source 1 index
id_rs2  in  REG_AW  ID source 2 index
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_rd  in  REG_AW  ID destination index
id_is_load  in  1  ID instruction is a load
flush  in  1  branch/jump taken; squash ID→EX transfer
ext_stall  in  1  downstream busy (e.g. data memory); hold stage
ex_ctrl  out  CTRL_W  registered control to EX
ex_valid  out  1  EX holds a real instruction
ex_rd  out  REG_AW  registered destination
ex_is_load  out  1  registered load flag
stall_req  out  1  freeze PC and IF/ID this cycle (combinational)
bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset values (rst high at clock edge): ex_ctrl=BUBBLE_VAL, ex_valid=0, ex_rd=0, ex_is_load=0, bubble_cnt=0, FSM=RUN, stall counter=0. stall_req evaluates to 0 out of reset.
- Hazard term hz = id_valid & ex_valid & ex_is_load & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). rd=x0 never hazards.
- FSM states are RUN and STALL. A counter scnt of width clog2(LU_STALL+1) tracks remaining bubbles.
- Per-edge priority, highest first: rst > flush > ext_stall > bubble (hz in RUN, or STALL) > normal load.
- flush: EX loads a bubble (BUBBLE_VAL, valid=0, rd=0, is_load=0). FSM goes to RUN and scnt=0. bubble_cnt increments. Flush overrides ext_stall and any stall in progress.
- ext_stall (no flush): all registers, FSM and scnt hold. bubble_cnt holds.
- RUN & hz: EX loads a bubble and bubble_cnt increments. If LU_STALL>1, go to STALL with scnt=LU_STALL-1; otherwise stay in RUN.
- STALL: EX loads a bubble, bubble_cnt increments and scnt decrements. Return to RUN when scnt reaches 0 after the decrement.
- Normal: EX loads id_ctrl, id_valid, id_rd and id_is_load. If id_valid=0, ex_ctrl=BUBBLE_VAL regardless of id_ctrl.
- stall_req = !flush & (ext_stall | (state==RUN & hz) | state==STALL).
- Latency: exactly one cycle, ID→EX. A stall of LU_STALL cycles produces LU_STALL consecutive bubbles, after which the held ID instruction enters EX.
- bubble_cnt saturates at all-ones and does not wrap.
- Reset mid-STALL aborts the stall immediately and gives reset values on the next cycle.
- flush and hz in the same cycle: flush wins, one bubble, no STALL entry.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 and id_ctrl=16'hBEEF → ex_ctrl=0, ex_valid=0, bubble_cnt=0, stall_req=0.
- Pass-through: id_ctrl=16'h1234, id_valid=1, no hazard → ex_ctrl=16'h1234 one cycle later, stall_req=0.
- Load-use with LU_STALL=2: EX holds load rd=5, ID has rs1=5 used → stall_req=1 for 2 cycles and ex_valid=0 for 2 cycles. The held instruction then enters EX and bubble_cnt=2.
- x0 exemption: load rd=0, ID rs1=0 used → no stall, ex_valid=1 next cycle.
- Flush during STALL (LU_STALL=3, flush in 2nd stall cycle) → stall_req drops that cycle, FSM=RUN, bubble_cnt=3, the next ID instruction loads normally.
- ext_stall while ex_ctrl=16'h00A5 for 4 cycles → ex_ctrl stays 16'h00A5, stall_req=1, bubble_cnt unchanged. Saturation check: preload near max (CNT_W=4), 20 bubbles → bubble_cnt=4'hF.
